// File: rtl/lsu_defs.sv
// Shared load/store definitions: FSM states, load_store_info bit positions and
// the decode and lane helpers used by the LSU memory stage.
package lsu_defs;

    localparam int unsigned LS_INFO_W = 8;

    localparam int unsigned LS_LB  = 7;
    localparam int unsigned LS_LH  = 6;
    localparam int unsigned LS_LW  = 5;
    localparam int unsigned LS_LBU = 4;
    localparam int unsigned LS_LHU = 3;
    localparam int unsigned LS_SB  = 2;
    localparam int unsigned LS_SH  = 1;
    localparam int unsigned LS_SW  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    typedef struct packed {
        logic      valid;
        logic      store;
        logic      sext;
        lsu_size_e size;
    } lsu_op_t;

    // Highest set bit of the one-hot operation field wins.
    function automatic lsu_op_t decode_op(input logic [LS_INFO_W-1:0] info);
        lsu_op_t op;
        op = '{valid: 1'b0, store: 1'b0, sext: 1'b0, size: SZ_BYTE};
        if      (info[LS_LB])  op = '{valid: 1'b1, store: 1'b0, sext: 1'b1, size: SZ_BYTE};
        else if (info[LS_LH])  op = '{valid: 1'b1, store: 1'b0, sext: 1'b1, size: SZ_HALF};
        else if (info[LS_LW])  op = '{valid: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_WORD};
        else if (info[LS_LBU]) op = '{valid: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_BYTE};
        else if (info[LS_LHU]) op = '{valid: 1'b1, store: 1'b0, sext: 1'b0, size: SZ_HALF};
        else if (info[LS_SB])  op = '{valid: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_BYTE};
        else if (info[LS_SH])  op = '{valid: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_HALF};
        else if (info[LS_SW])  op = '{valid: 1'b1, store: 1'b1, sext: 1'b0, size: SZ_WORD};
        return op;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_be(input lsu_size_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so the byte enables alone select the target.
    function automatic logic [31:0] store_lanes(input lsu_size_e size, input logic [31:0] data);
        logic [31:0] wdata;
        case (size)
            SZ_BYTE: wdata = {4{data[7:0]}};
            SZ_HALF: wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the read word down to the accessed
// byte offset and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  lsu_size_e   size,
    input  logic        sext,
    output logic [31:0] result_c
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        result_c = shifted;
        case (size)
            SZ_BYTE: result_c = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: result_c = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: result_c = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one outstanding req/gnt/rvalid access, core stall
// while busy, aligned load return and a bus timeout abort.
module lsu_mem_stage
    import lsu_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [LS_INFO_W-1:0] load_store_info_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [31:0]          rs2_data_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [31:0]          dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [31:0]          dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [31:0]          dmem_rdata_i,
    output logic                 lsu_stall_o,
    output logic                 lsu_done_o,
    output logic [31:0]          load_data_o,
    output logic                 misalign_o,
    output logic                 bus_err_o
);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             store_q;
    logic             sext_q;
    lsu_size_e        size_q;
    logic [1:0]       off_q;

    lsu_op_t          op_c;
    logic             mis_c;
    logic             start_c;
    logic             timeout_c;
    logic [31:0]      ext_c;

    assign op_c      = decode_op(load_store_info_i);
    assign mis_c     = op_c.valid && is_misaligned(op_c.size, mem_addr_i[1:0]);
    assign start_c   = (state_q == ST_IDLE) && op_c.valid && !mis_c;
    assign timeout_c = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    assign misalign_o  = (state_q == ST_IDLE) && mis_c;
    assign lsu_stall_o = start_c || (state_q == ST_REQ) || (state_q == ST_WAIT);

    lsu_load_align u_load_align (
        .rdata    (dmem_rdata_i),
        .offset   (off_q),
        .size     (size_q),
        .sext     (sext_q),
        .result_c (ext_c)
    );

    // Control FSM; bus and completion outputs are updated with the state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            sext_q       <= 1'b0;
            size_q       <= SZ_BYTE;
            off_q        <= 2'b00;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            lsu_done_o   <= 1'b0;
            load_data_o  <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            lsu_done_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        state_q      <= ST_REQ;
                        cnt_q        <= '0;
                        store_q      <= op_c.store;
                        sext_q       <= op_c.sext;
                        size_q       <= op_c.size;
                        off_q        <= mem_addr_i[1:0];
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= op_c.store;
                        dmem_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dmem_be_o    <= lane_be(op_c.size, mem_addr_i[1:0]);
                        dmem_wdata_o <= store_lanes(op_c.size, rs2_data_i);
                        load_data_o  <= '0;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Grant takes priority over a coincident timeout.
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (store_q) begin
                            state_q    <= ST_DONE;
                            lsu_done_o <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else if (timeout_c) begin
                        dmem_req_o  <= 1'b0;
                        state_q     <= ST_DONE;
                        lsu_done_o  <= 1'b1;
                        bus_err_o   <= 1'b1;
                        load_data_o <= '0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (dmem_rvalid_i) begin
                        state_q     <= ST_DONE;
                        lsu_done_o  <= 1'b1;
                        load_data_o <= ext_c;
                    end else if (timeout_c) begin
                        state_q     <= ST_DONE;
                        lsu_done_o  <= 1'b1;
                        bus_err_o   <= 1'b1;
                        load_data_o <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus random operations
// compared cycle by cycle against a transaction-level reference model.
module tb_lsu_mem_stage;

    localparam int T = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  load_store_info_i;
    logic [31:0] mem_addr_i;
    logic [31:0] rs2_data_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        lsu_stall_o;
    logic        lsu_done_o;
    logic [31:0] load_data_o;
    logic        misalign_o;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    lsu_mem_stage #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .load_store_info_i (load_store_info_i),
        .mem_addr_i        (mem_addr_i),
        .rs2_data_i        (rs2_data_i),
        .dmem_req_o        (dmem_req_o),
        .dmem_we_o         (dmem_we_o),
        .dmem_addr_o       (dmem_addr_o),
        .dmem_be_o         (dmem_be_o),
        .dmem_wdata_o      (dmem_wdata_o),
        .dmem_gnt_i        (dmem_gnt_i),
        .dmem_rvalid_i     (dmem_rvalid_i),
        .dmem_rdata_i      (dmem_rdata_i),
        .lsu_stall_o       (lsu_stall_o),
        .lsu_done_o        (lsu_done_o),
        .load_data_o       (load_data_o),
        .misalign_o        (misalign_o),
        .bus_err_o         (bus_err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, expv, $time);
        end
    endtask

    // Reference load result; hi is the winning load_store_info bit index.
    function automatic logic [31:0] model_load(input int hi, input logic [31:0] rdata, input logic [1:0] off);
        logic [31:0] s;
        s = rdata >> (8 * off);
        case (hi)
            7:       return {{24{s[7]}}, s[7:0]};
            6:       return {{16{s[15]}}, s[15:0]};
            4:       return {24'h0, s[7:0]};
            3:       return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Runs one instruction from its IDLE cycle; g = REQ cycles before gnt (>= T: never),
    // r = WAIT cycles before rvalid. Entered and left at posedge+1.
    task automatic run_op(input logic [7:0] info, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int g, input int r);
        int         hi;
        int         size;
        int         done_cyc;
        int         req_last;
        bit         store;
        bit         mis;
        bit         granted;
        bit         err;
        logic [3:0] be;
        logic [31:0] wd;
        logic [31:0] ld;
        hi = -1;
        for (int i = 7; i >= 0; i--) if (hi < 0 && info[i]) hi = i;
        load_store_info_i = info;
        mem_addr_i        = addr;
        rs2_data_i        = rs2;
        dmem_rdata_i      = rdata;
        dmem_gnt_i        = 1'b0;
        dmem_rvalid_i     = 1'b0;
        if (hi < 0) begin
            #1;
            check_eq("nop_stall", 32'(lsu_stall_o), 0);
            check_eq("nop_req", 32'(dmem_req_o), 0);
            @(posedge clk_i); #1;
            return;
        end
        size  = (hi == 7 || hi == 4 || hi == 2) ? 1 : (hi == 6 || hi == 3 || hi == 1) ? 2 : 4;
        store = (hi <= 2);
        mis   = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
        if (mis) begin
            #1;
            check_eq("mis_flag", 32'(misalign_o), 1);
            check_eq("mis_stall", 32'(lsu_stall_o), 0);
            check_eq("mis_req", 32'(dmem_req_o), 0);
            check_eq("mis_done", 32'(lsu_done_o), 0);
            @(posedge clk_i); #1;
            return;
        end
        be = (size == 1) ? (4'b0001 << addr[1:0]) : (size == 2) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = (size == 1) ? {4{rs2[7:0]}} : (size == 2) ? {2{rs2[15:0]}} : rs2;
        ld = model_load(hi, rdata, addr[1:0]);
        granted = (g <= T - 1);
        if (!granted) begin
            req_last = T;
            done_cyc = T + 1;
            err      = 1'b1;
        end else begin
            req_last = 1 + g;
            if (store) begin
                done_cyc = g + 2;
                err      = 1'b0;
            end else if ((g + 1 + r <= T - 1) || r == 0) begin
                done_cyc = g + r + 3;
                err      = 1'b0;
            end else begin
                done_cyc = ((T - 1 > g + 1) ? T - 1 : g + 1) + 2;
                err      = 1'b1;
            end
        end
        if (err) ld = '0;
        for (int c = 0; c <= done_cyc; c++) begin
            dmem_gnt_i    = granted && (c == 1 + g);
            dmem_rvalid_i = (!store && granted && c == g + 2 + r && c < done_cyc)
                         || (c >= 1 && c <= req_last && $urandom_range(0, 1) == 1);
            #1;
            check_eq("stall", 32'(lsu_stall_o), 32'(c < done_cyc));
            check_eq("req", 32'(dmem_req_o), 32'(c >= 1 && c <= req_last));
            check_eq("done", 32'(lsu_done_o), 32'(c == done_cyc));
            check_eq("bus_err", 32'(bus_err_o), 32'(c == done_cyc && err));
            if (c == 0) check_eq("mis_low", 32'(misalign_o), 0);
            if (c >= 1 && c <= req_last) begin
                check_eq("addr", dmem_addr_o, {addr[31:2], 2'b00});
                check_eq("we", 32'(dmem_we_o), 32'(store));
                check_eq("be", 32'(dmem_be_o), 32'(be));
                if (store) check_eq("wdata", dmem_wdata_o, wd);
            end
            if (c == done_cyc && (!store || err)) check_eq("load_data", load_data_o, ld);
            @(posedge clk_i); #1;
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  info;
        logic [31:0] addr;
        int          sel;
        int          g;
        rst_n_i           = 1'b0;
        load_store_info_i = '0;
        mem_addr_i        = '0;
        rs2_data_i        = '0;
        dmem_gnt_i        = 1'b0;
        dmem_rvalid_i     = 1'b0;
        dmem_rdata_i      = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_req", 32'(dmem_req_o), 0);
        check_eq("rst_we", 32'(dmem_we_o), 0);
        check_eq("rst_addr", dmem_addr_o, 0);
        check_eq("rst_be", 32'(dmem_be_o), 0);
        check_eq("rst_wdata", dmem_wdata_o, 0);
        check_eq("rst_done", 32'(lsu_done_o), 0);
        check_eq("rst_ldata", load_data_o, 0);
        check_eq("rst_err", 32'(bus_err_o), 0);
        check_eq("rst_stall", 32'(lsu_stall_o), 0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        run_op(8'h04, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 0);     // sb
        run_op(8'h40, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1);     // lh
        run_op(8'h08, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1);     // lhu
        run_op(8'h20, 32'h0000_2000, 32'h0, 32'h8001_1234, 0, 0);     // lw
        run_op(8'h20, 32'h0000_3001, 32'h0, 32'h0, 0, 0);             // lw misaligned
        run_op(8'h01, 32'h0000_4000, 32'h1234_5678, 32'h0, 3, 0);     // sw, gnt held off
        run_op(8'h80, 32'h0000_5001, 32'h0, 32'h0, 0, 99);            // lb timeout
        run_op(8'h80, 32'h0000_5001, 32'h0, 32'h0000_F000, 3, 0);     // gnt on last cycle
        run_op(8'h80, 32'h0000_5001, 32'h0, 32'h0000_F000, 3, 1);
        run_op(8'h02, 32'h0000_6002, 32'hCAFE_BABE, 32'h0, 99, 0);    // store, never granted
        run_op(8'hA1, 32'h0000_7003, 32'h0, 32'h8000_0000, 1, 0);     // lb wins
        run_op(8'h03, 32'h0000_7002, 32'h0000_BEEF, 32'h0, 0, 0);     // sh wins
        run_op(8'h00, 32'h0000_7000, 32'h0, 32'h0, 0, 0);

        // Async reset while in REQ (phase 0) and in WAIT (phase 1).
        for (int phase = 0; phase < 2; phase++) begin
            load_store_info_i = 8'h80;
            mem_addr_i        = 32'h0000_0040;
            #1;
            @(posedge clk_i); #1;
            dmem_gnt_i = (phase == 1);
            @(posedge clk_i); #1;
            dmem_gnt_i = 1'b0;
            check_eq("pre_rst_stall", 32'(lsu_stall_o), 1);
            check_eq("pre_rst_req", 32'(dmem_req_o), 32'(phase == 0));
            rst_n_i           = 1'b0;
            load_store_info_i = '0;
            #1;
            check_eq("arst_req", 32'(dmem_req_o), 0);
            check_eq("arst_stall", 32'(lsu_stall_o), 0);
            check_eq("arst_done", 32'(lsu_done_o), 0);
            @(posedge clk_i); #1;
            rst_n_i = 1'b1;
            @(posedge clk_i); #1;
            run_op(8'h10, 32'h0000_0000, 32'h0, 32'h0000_00F0, 0, 0);  // lbu after reset
        end

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       info = 8'b1 << sel;
            else if (sel == 8) info = 8'($urandom);
            else               info = '0;
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            g = $urandom_range(0, 4);
            if (g == 4) g = 99;
            run_op(info, addr, $urandom, $urandom, g, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
